// File: rtl/led_frame_scheduler_if.sv
// Pixel lookup and serializer handshake bundle for the LED frame scheduler.
// The master side (the scheduler) drives the lookup address and offers colors.
interface led_frame_scheduler_if #(
    parameter int unsigned AddrW = 9
) ();
    logic [AddrW-1:0] pix_addr;
    logic [23:0]      pix_data;
    logic             px_valid;
    logic [23:0]      px_data;
    logic             px_ready;
    logic             px_busy;

    modport master (
        output pix_addr, px_valid, px_data,
        input  pix_data, px_ready, px_busy
    );

    modport slave (
        input  pix_addr, px_valid, px_data,
        output pix_data, px_ready, px_busy
    );
endinterface

// File: rtl/led_frame_scheduler.sv
// Walks every pixel of every cube face, fetching each color and handing it to the WS2812B
// serializer, then waits for the chain to drain and holds the latch gap before finishing.
module led_frame_scheduler #(
    parameter int unsigned PIXELS_PER_FACE = 64,
    parameter int unsigned FACES           = 6,
    parameter int unsigned LATCH_CYCLES    = 2000,
    parameter int unsigned REFRESH_CYCLES  = 0
) (
    input  logic                          clk_i,
    input  logic                          rst_ni,
    input  logic                          frame_req_i,
    led_frame_scheduler_if.master         px_if,
    output logic                          orient_lock_o,
    output logic                          busy_o,
    output logic                          frame_done_o
);
    localparam int unsigned TotalPix = FACES * PIXELS_PER_FACE;
    localparam int unsigned AddrW    = (TotalPix > 1) ? $clog2(TotalPix) : 1;
    localparam int unsigned PixW     = (PIXELS_PER_FACE > 1) ? $clog2(PIXELS_PER_FACE) : 1;
    localparam int unsigned FaceW    = (FACES > 1) ? $clog2(FACES) : 1;
    localparam int unsigned LatW     = (LATCH_CYCLES > 1) ? $clog2(LATCH_CYCLES) : 1;
    localparam int unsigned RefW     = (REFRESH_CYCLES > 1) ? $clog2(REFRESH_CYCLES) : 1;

    localparam logic [PixW-1:0]  PixMax  = PixW'(PIXELS_PER_FACE - 1);
    localparam logic [FaceW-1:0] FaceMax = FaceW'(FACES - 1);
    localparam logic [LatW-1:0]  LatMax  = LatW'(LATCH_CYCLES - 1);
    localparam logic [RefW-1:0]  RefMax  = RefW'((REFRESH_CYCLES > 0) ? REFRESH_CYCLES - 1 : 0);

    typedef enum logic [2:0] {
        StIdle,
        StFetch,
        StLoad,
        StOffer,
        StDrain,
        StLatch
    } state_e;

    state_e            state_q, state_d;
    logic [FaceW-1:0]  face_q, face_d;
    logic [PixW-1:0]   pixel_q, pixel_d;
    logic [AddrW-1:0]  addr_q, addr_d;
    logic [23:0]       data_q, data_d;
    logic [LatW-1:0]   lat_q, lat_d;
    logic [RefW-1:0]   ref_q, ref_d;
    logic              pending_q, pending_d;
    logic              done_q, done_d;
    logic              refresh_hit;
    logic              start;
    logic              last_pix;

    assign refresh_hit = (REFRESH_CYCLES != 0) && (ref_q == RefMax);
    assign start       = frame_req_i | pending_q | refresh_hit;
    assign last_pix    = (face_q == FaceMax) && (pixel_q == PixMax);

    always_comb begin
        state_d   = state_q;
        face_d    = face_q;
        pixel_d   = pixel_q;
        addr_d    = addr_q;
        data_d    = data_q;
        lat_d     = lat_q;
        pending_d = pending_q;
        ref_d     = ref_q;
        done_d    = 1'b0;

        if (REFRESH_CYCLES != 0 && !refresh_hit) begin
            ref_d = ref_q + 1'b1;
        end
        // Requests arriving mid-frame (including the latch terminal cycle) collapse into one.
        if (frame_req_i && state_q != StIdle) begin
            pending_d = 1'b1;
        end

        case (state_q)
            StIdle: begin
                if (start) begin
                    state_d   = StFetch;
                    pending_d = 1'b0;
                    ref_d     = '0;
                    addr_d    = AddrW'({face_q, pixel_q});
                end
            end
            StFetch: begin
                state_d = StLoad;
            end
            StLoad: begin
                data_d  = px_if.pix_data;
                state_d = StOffer;
            end
            StOffer: begin
                if (px_if.px_ready) begin
                    if (last_pix) begin
                        state_d = StDrain;
                    end else begin
                        if (pixel_q == PixMax) begin
                            pixel_d = '0;
                            face_d  = face_q + 1'b1;
                        end else begin
                            pixel_d = pixel_q + 1'b1;
                        end
                        // Power-of-two face size lets the linear index be a plain concatenation.
                        addr_d  = AddrW'({face_d, pixel_d});
                        state_d = StFetch;
                    end
                end
            end
            StDrain: begin
                if (!px_if.px_busy) begin
                    lat_d   = '0;
                    state_d = StLatch;
                end
            end
            StLatch: begin
                if (lat_q == LatMax) begin
                    done_d  = 1'b1;
                    face_d  = '0;
                    pixel_d = '0;
                    lat_d   = '0;
                    state_d = StIdle;
                end else begin
                    lat_d = lat_q + 1'b1;
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q   <= StIdle;
            face_q    <= '0;
            pixel_q   <= '0;
            addr_q    <= '0;
            data_q    <= '0;
            lat_q     <= '0;
            ref_q     <= '0;
            pending_q <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            face_q    <= face_d;
            pixel_q   <= pixel_d;
            addr_q    <= addr_d;
            data_q    <= data_d;
            lat_q     <= lat_d;
            ref_q     <= ref_d;
            pending_q <= pending_d;
            done_q    <= done_d;
        end
    end

    assign px_if.pix_addr = addr_q;
    assign px_if.px_valid = (state_q == StOffer);
    assign px_if.px_data  = data_q;
    assign orient_lock_o  = (state_q != StIdle);
    assign busy_o         = (state_q != StIdle);
    assign frame_done_o   = done_q;

endmodule

// File: tb/tb_led_frame_scheduler.sv
// Directed bench for led_frame_scheduler: basic frame, backpressure, drain, queued requests,
// auto-refresh period and mid-frame reset, all against hand-derived cycle timings.
module tb_led_frame_scheduler;
    localparam int unsigned Ppf   = 4;
    localparam int unsigned Faces = 2;
    localparam int unsigned Lat   = 10;
    localparam int unsigned NPix  = Ppf * Faces;
    localparam int unsigned AddrW = 3;

    logic clk;
    logic rst_n;
    logic frame_req;
    logic lock, busy, done;
    logic frame_req2;
    logic lock2, busy2, done2;

    int checks   = 0;
    int failures = 0;
    int acc_cnt  = 0;
    int cyc      = 0;
    int starts[$];
    logic b2_prev = 1'b0;

    led_frame_scheduler_if #(.AddrW(AddrW)) pif  ();
    led_frame_scheduler_if #(.AddrW(AddrW)) pif2 ();

    led_frame_scheduler #(
        .PIXELS_PER_FACE(Ppf),
        .FACES          (Faces),
        .LATCH_CYCLES   (Lat),
        .REFRESH_CYCLES (0)
    ) dut (
        .clk_i        (clk),
        .rst_ni       (rst_n),
        .frame_req_i  (frame_req),
        .px_if        (pif),
        .orient_lock_o(lock),
        .busy_o       (busy),
        .frame_done_o (done)
    );

    led_frame_scheduler #(
        .PIXELS_PER_FACE(Ppf),
        .FACES          (Faces),
        .LATCH_CYCLES   (Lat),
        .REFRESH_CYCLES (200)
    ) dut_refresh (
        .clk_i        (clk),
        .rst_ni       (rst_n),
        .frame_req_i  (frame_req2),
        .px_if        (pif2),
        .orient_lock_o(lock2),
        .busy_o       (busy2),
        .frame_done_o (done2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [23:0] pat(input int a);
        return {8'h3C, 8'(a), 8'(a) ^ 8'hA5};
    endfunction

    // Color lookup with one cycle of latency.
    always @(posedge clk) begin
        pif.pix_data  <= pat(int'(pif.pix_addr));
        pif2.pix_data <= 24'h0;
    end

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (pif.px_valid && pif.px_ready) acc_cnt <= acc_cnt + 1;
        if (busy2 && !b2_prev) starts.push_back(cyc);
        b2_prev <= busy2;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Entered in the FETCH cycle of pixel 0; returns in the frame_done cycle.
    task automatic run_frame(input int stall_pix, input int stall_len, input int drain_len,
                             input bit req_mid, input bit req_term);
        int   acc0;
        logic early;
        acc0  = acc_cnt;
        early = 1'b0;
        check_eq("start_busy", busy, 1);
        check_eq("start_lock", lock, 1);
        for (int i = 0; i < int'(NPix); i++) begin
            check_eq("fetch_addr", pif.pix_addr, i);
            check_eq("fetch_valid", pif.px_valid, 0);
            if (req_mid && (i == 1 || i == 2 || i == 4)) frame_req = 1'b1;
            if (i == stall_pix) pif.px_ready = 1'b0;
            if (i == int'(NPix) - 1 && drain_len > 0) pif.px_busy = 1'b1;
            tick();
            frame_req = 1'b0;
            tick();
            check_eq("offer_valid", pif.px_valid, 1);
            check_eq("offer_data", pif.px_data, pat(i));
            if (i == stall_pix) begin
                for (int k = 0; k < stall_len; k++) begin
                    tick();
                    check_eq("stall_valid", pif.px_valid, 1);
                    check_eq("stall_data", pif.px_data, pat(i));
                    check_eq("stall_addr", pif.pix_addr, i);
                end
                pif.px_ready = 1'b1;
            end
            tick();
        end
        check_eq("drain_valid", pif.px_valid, 0);
        check_eq("drain_lock", lock, 1);
        check_eq("accepts", acc_cnt - acc0, NPix);
        for (int k = 0; k < drain_len; k++) begin
            early = early | done | ~lock;
            tick();
        end
        pif.px_busy = 1'b0;
        tick();
        // Now in LATCH with count 0; frame_done follows LATCH_CYCLES edges later.
        for (int k = 0; k < int'(Lat); k++) begin
            early = early | done | ~lock;
            if (k == int'(Lat) - 1 && req_term) frame_req = 1'b1;
            tick();
            frame_req = 1'b0;
        end
        check_eq("no_early_done", early, 0);
        check_eq("done_pulse", done, 1);
        check_eq("done_lock", lock, 0);
        check_eq("done_busy", busy, 0);
    endtask

    initial begin
        logic idle_err;
        int   p0, p1;
        rst_n         = 1'b0;
        frame_req     = 1'b0;
        frame_req2    = 1'b0;
        pif.px_ready  = 1'b1;
        pif.px_busy   = 1'b0;
        pif2.px_ready = 1'b1;
        pif2.px_busy  = 1'b0;
        repeat (3) tick();
        check_eq("rst_valid", pif.px_valid, 0);
        check_eq("rst_lock", lock, 0);
        check_eq("rst_busy", busy, 0);
        check_eq("rst_done", done, 0);
        check_eq("rst_addr", pif.pix_addr, 0);
        check_eq("rst_data", pif.px_data, 0);
        rst_n = 1'b1;
        tick();

        // Basic frame
        frame_req = 1'b1;
        tick();
        frame_req = 1'b0;
        run_frame(-1, 0, 0, 1'b0, 1'b0);
        tick();
        check_eq("done_single", done, 0);
        check_eq("idle_after_basic", busy, 0);

        // Backpressure on pixel 3 plus a 20-cycle drain
        frame_req = 1'b1;
        tick();
        frame_req = 1'b0;
        run_frame(3, 5, 20, 1'b0, 1'b0);
        tick();
        check_eq("idle_after_stall", busy, 0);

        // Queued requests: mid-frame pulses plus terminal-cycle pulse give one extra frame
        frame_req = 1'b1;
        tick();
        frame_req = 1'b0;
        run_frame(-1, 0, 0, 1'b1, 1'b1);
        tick();
        run_frame(-1, 0, 0, 1'b0, 1'b1);
        tick();
        run_frame(-1, 0, 0, 1'b0, 1'b0);
        idle_err = 1'b0;
        for (int k = 0; k < 50; k++) begin
            tick();
            idle_err = idle_err | busy | lock;
        end
        check_eq("no_extra_frame", idle_err, 0);

        // Auto-refresh instance runs free from reset release
        repeat (500) tick();
        check_eq("refresh_starts", (starts.size() >= 3) ? 1 : 0, 1);
        p0 = (starts.size() >= 3) ? starts[1] - starts[0] : -1;
        p1 = (starts.size() >= 3) ? starts[2] - starts[1] : -1;
        check_eq("refresh_period0", p0, 200);
        check_eq("refresh_period1", p1, 200);

        // Reset during pixel 5 OFFER, with a pending request that must be lost
        frame_req = 1'b1;
        tick();
        frame_req = 1'b0;
        for (int i = 0; i < 5; i++) begin
            if (i == 2) frame_req = 1'b1;
            tick();
            frame_req = 1'b0;
            tick();
            tick();
        end
        check_eq("pre_rst_addr", pif.pix_addr, 5);
        tick();
        tick();
        check_eq("pre_rst_valid", pif.px_valid, 1);
        rst_n = 1'b0;
        tick();
        check_eq("mid_rst_valid", pif.px_valid, 0);
        check_eq("mid_rst_lock", lock, 0);
        check_eq("mid_rst_busy", busy, 0);
        check_eq("mid_rst_addr", pif.pix_addr, 0);
        rst_n    = 1'b1;
        idle_err = 1'b0;
        for (int k = 0; k < 20; k++) begin
            tick();
            idle_err = idle_err | busy;
        end
        check_eq("pending_lost", idle_err, 0);
        frame_req = 1'b1;
        tick();
        frame_req = 1'b0;
        run_frame(-1, 0, 0, 1'b0, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
